// File: rtl/led_activity_pkg.sv
// Shared types and the saturating PWM compare for the LED activity block.
package led_activity_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'b00,
    LED_ON      = 2'b01,
    LED_BREATHE = 2'b10,
    LED_ACT     = 2'b11
  } led_mode_e;

  // Widest PWM level the compare helper handles.
  localparam int LVL_MAX_W = 16;

  // An all-ones level means fully on; otherwise lit while the carrier is below the level.
  function automatic logic pwm_on(input logic [LVL_MAX_W-1:0] level,
                                  input logic [LVL_MAX_W-1:0] pwm,
                                  input logic [LVL_MAX_W-1:0] full);
    logic on_v;
    if (level == full) begin
      on_v = 1'b1;
    end else begin
      on_v = (pwm < level);
    end
    return on_v;
  endfunction

endpackage

// File: rtl/led_activity_if.sv
// Per-channel control and LED/busy status bundle for led_activity.
interface led_activity_if #(
  parameter int NUM_CH = 3,
  parameter int PWM_W  = 8
);
  logic [2*NUM_CH-1:0]     mode;
  logic [PWM_W*NUM_CH-1:0] bright;
  logic [NUM_CH-1:0]       act;
  logic [NUM_CH-1:0]       led;
  logic [NUM_CH-1:0]       busy;

  modport master (output mode, output bright, output act, input led, input busy);
  modport slave  (input mode, input bright, input act, output led, output busy);
endinterface

// File: rtl/led_activity_ch.sv
// One LED channel: retriggerable hold timer, mode select, PWM compare, output flops.
module led_activity_ch
  import led_activity_pkg::*;
#(
  parameter int PWM_W       = 8,
  parameter int HOLD_CYCLES = 2000000
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  led_mode_e        mode,
  input  logic [PWM_W-1:0] bright,
  input  logic             act,
  input  logic [PWM_W-1:0] pwm,
  input  logic             blink,
  input  logic [PWM_W-1:0] breathe_level,
  output logic             led,
  output logic             busy
);

  localparam int                    HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]     HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]     HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0]     HOLD_ONE  = HOLD_W'(1);
  localparam logic [LVL_MAX_W-1:0]  FULL      = LVL_MAX_W'((64'd1 << PWM_W) - 64'd1);

  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_nxt_s;
  logic              busy_nxt_s;
  logic              led_nxt_s;
  logic [PWM_W-1:0]  scaled_s;
  logic              on_bright_s;
  logic              on_breathe_s;

  // Next hold count, busy flag and LED level from current state and controls.
  always_comb begin
    busy_nxt_s = act | (hold_r != HOLD_ZERO);
    if (act) begin
      hold_nxt_s = HOLD_LOAD;
    end else if (hold_r != HOLD_ZERO) begin
      hold_nxt_s = hold_r - HOLD_ONE;
    end else begin
      hold_nxt_s = hold_r;
    end
    scaled_s     = PWM_W'(((2*PWM_W)'(breathe_level) * (2*PWM_W)'(bright)) >> PWM_W);
    on_bright_s  = pwm_on(LVL_MAX_W'(bright), LVL_MAX_W'(pwm), FULL);
    on_breathe_s = pwm_on(LVL_MAX_W'(scaled_s), LVL_MAX_W'(pwm), FULL);
    case (mode)
      LED_OFF:     led_nxt_s = 1'b0;
      LED_ON:      led_nxt_s = on_bright_s;
      LED_BREATHE: led_nxt_s = on_breathe_s;
      LED_ACT:     led_nxt_s = busy_nxt_s & blink & on_bright_s;
      default:     led_nxt_s = 1'b0;
    endcase
  end

  // Hold timer and registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold_r <= HOLD_ZERO;
      led    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      hold_r <= hold_nxt_s;
      led    <= led_nxt_s;
      busy   <= busy_nxt_s;
    end
  end

endmodule

// File: rtl/led_activity.sv
// Multi-channel LED driver sharing one phase counter across channels.
// Optional perceptual breathing curve: define LED_ACTIVITY_GAMMA_EN.
module led_activity
  import led_activity_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = 27,
  parameter int PWM_W       = 8,
  parameter int HOLD_CYCLES = 2000000,
  parameter int BLINK_BIT   = 21
) (
  input  logic           clk_sys,
  input  logic           reset,
  led_activity_if.slave  bus
);

  logic [CNT_W-1:0]  cnt_r;
  logic [PWM_W-1:0]  tri_lvl_s;
  logic [PWM_W-1:0]  pwm_s;
  logic              blink_s;
  logic [PWM_W-1:0]  level_s;
  logic [NUM_CH-1:0] led_s;
  logic [NUM_CH-1:0] busy_s;

  // Free-running phase counter, wraps after all-ones.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Triangle mirrors about the MSB so the wrap is seamless.
  always_comb begin
    if (cnt_r[CNT_W-1]) begin
      tri_lvl_s = cnt_r[CNT_W-2 -: PWM_W];
    end else begin
      tri_lvl_s = ~cnt_r[CNT_W-2 -: PWM_W];
    end
  end

`ifdef LED_ACTIVITY_GAMMA_EN
  logic [PWM_W-1:0] pwm_d_r;
  logic             blink_d_r;
  logic [PWM_W-1:0] gam_r;

  // Squared level is registered; carrier and blink are delayed to stay aligned with it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pwm_d_r   <= {PWM_W{1'b0}};
      blink_d_r <= 1'b0;
      gam_r     <= {PWM_W{1'b0}};
    end else begin
      pwm_d_r   <= cnt_r[PWM_W-1:0];
      blink_d_r <= cnt_r[BLINK_BIT];
      gam_r     <= PWM_W'(((2*PWM_W)'(tri_lvl_s) * (2*PWM_W)'(tri_lvl_s)) >> PWM_W);
    end
  end

  assign pwm_s   = pwm_d_r;
  assign blink_s = blink_d_r;
  assign level_s = gam_r;
`else
  assign pwm_s   = cnt_r[PWM_W-1:0];
  assign blink_s = cnt_r[BLINK_BIT];
  assign level_s = tri_lvl_s;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_activity_ch #(
      .PWM_W       (PWM_W),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ch (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .mode          (led_mode_e'(bus.mode[2*i +: 2])),
      .bright        (bus.bright[PWM_W*i +: PWM_W]),
      .act           (bus.act[i]),
      .pwm           (pwm_s),
      .blink         (blink_s),
      .breathe_level (level_s),
      .led           (led_s[i]),
      .busy          (busy_s[i])
    );
  end

  assign bus.led  = led_s;
  assign bus.busy = busy_s;

endmodule

// File: tb/tb_led_activity.sv
// Self-checking bench for led_activity: reference model feeding a scoreboard,
// a vector table of duty/busy counts, and hand-written corner sequences.
module tb_led_activity;

  localparam int NUM_CH = 3, CNT_W = 12, PWM_W = 4, HOLD_CYCLES = 10, BLINK_BIT = 6;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  led_activity_if #(.NUM_CH(NUM_CH), .PWM_W(PWM_W)) bus ();

  led_activity #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PWM_W(PWM_W),
    .HOLD_CYCLES(HOLD_CYCLES), .BLINK_BIT(BLINK_BIT)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct packed { logic [2:0] led; logic [2:0] busy; } exp_t;
  typedef struct {
    logic [5:0]       mode;
    logic [11:0]      bright;
    logic [2:0]       act;
    bit               act_hold;
    int               cycles;
    logic [2:0][7:0]  exp_led;
    logic [2:0][7:0]  exp_busy;
  } vec_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  logic        drv_reset;
  logic [5:0]  drv_mode;
  logic [11:0] drv_bright;
  logic [2:0]  drv_act;
  logic [11:0] m_cnt, m_cnt_d, last_cnt;
  logic [3:0]  m_gam;
  int          m_hold[3];
  logic [2:0]  obs_led, obs_busy;
  int          duty[256];
  vec_t        tbl[5];

  function automatic logic on_f(input logic [3:0] lvl, input logic [3:0] pw);
    if (lvl == 4'hF) return 1'b1;
    return pw < lvl;
  endfunction

  function automatic logic [3:0] tri_f(input logic [11:0] c);
    logic [3:0] t;
    t = c[10:7];
    return c[11] ? t : ~t;
  endfunction

  function automatic logic [3:0] scale_f(input logic [3:0] x, input logic [3:0] b);
    logic [7:0] p;
    p = {4'h0, x} * {4'h0, b};
    return p[7:4];
  endfunction

  function automatic logic [11:0] use_cnt();
`ifdef LED_ACTIVITY_GAMMA_EN
    return m_cnt_d;
`else
    return m_cnt;
`endif
  endfunction

  function automatic logic [3:0] breathe_lvl();
`ifdef LED_ACTIVITY_GAMMA_EN
    return m_gam;
`else
    return tri_f(m_cnt);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One clock: predict, drive, advance the model, then compare the popped expectation.
  task automatic step();
    exp_t e, got;
    logic [11:0] cu;
    logic [11:0] old;
    logic [1:0]  m;
    logic [3:0]  b;
    logic        bc, l;
    cu = use_cnt();
    for (int ch = 0; ch < 3; ch++) begin
      m  = drv_mode[2*ch +: 2];
      b  = drv_bright[4*ch +: 4];
      bc = drv_act[ch] || (m_hold[ch] != 0);
      case (m)
        2'd0:    l = 1'b0;
        2'd1:    l = on_f(b, cu[3:0]);
        2'd2:    l = on_f(scale_f(breathe_lvl(), b), cu[3:0]);
        default: l = bc & cu[6] & on_f(b, cu[3:0]);
      endcase
      e.led[ch]  = drv_reset ? 1'b0 : l;
      e.busy[ch] = drv_reset ? 1'b0 : bc;
    end
    sb_q.push_back(e);
    reset      = drv_reset;
    bus.mode   = drv_mode;
    bus.bright = drv_bright;
    bus.act    = drv_act;
    last_cnt   = cu;
    @(posedge clk_sys);
    old = m_cnt;
    if (drv_reset) begin
      m_cnt = 12'd0; m_cnt_d = 12'd0; m_gam = 4'd0;
      for (int ch = 0; ch < 3; ch++) m_hold[ch] = 0;
    end else begin
      m_cnt   = m_cnt + 12'd1;
      m_cnt_d = old;
      m_gam   = scale_f(tri_f(old), tri_f(old));
      for (int ch = 0; ch < 3; ch++) begin
        if (drv_act[ch]) m_hold[ch] = HOLD_CYCLES - 1;
        else if (m_hold[ch] != 0) m_hold[ch] = m_hold[ch] - 1;
      end
    end
    #1;
    obs_led  = bus.led;
    obs_busy = bus.busy;
    got      = {obs_led, obs_busy};
    e        = sb_q.pop_front();
    check("sb_led_busy", 32'(got), 32'(e));
  endtask

  initial begin
    logic [11:0] cu2;
    int guard;
    int cl[3], cb[3];

    tbl[0] = '{6'b01_01_01, 12'h04F, 3'b000, 1'b1, 64,  {8'd0, 8'd16, 8'd64},  {8'd0, 8'd0, 8'd0}};
    tbl[1] = '{6'b01_01_00, 12'hE80, 3'b000, 1'b1, 32,  {8'd28, 8'd16, 8'd0},  {8'd0, 8'd0, 8'd0}};
    tbl[2] = '{6'b00_00_00, 12'hFFF, 3'b111, 1'b0, 32,  {8'd0, 8'd0, 8'd0},    {8'd10, 8'd10, 8'd10}};
    tbl[3] = '{6'b11_11_11, 12'h04F, 3'b111, 1'b1, 128, {8'd0, 8'd16, 8'd64},  {8'd128, 8'd128, 8'd128}};
    tbl[4] = '{6'b00_00_00, 12'h04F, 3'b000, 1'b1, 16,  {8'd0, 8'd0, 8'd0},    {8'd9, 8'd9, 8'd9}};

    m_cnt = 12'd0; m_cnt_d = 12'd0; m_gam = 4'd0;
    for (int ch = 0; ch < 3; ch++) m_hold[ch] = 0;
    drv_reset = 1'b1; drv_mode = 6'd0; drv_bright = 12'd0; drv_act = 3'd0;
    repeat (3) step();
    check("init_reset_led", 32'(obs_led), 32'd0);
    drv_reset = 1'b0;

    // Table: constant controls, count lit and busy cycles per channel.
    for (int v = 0; v < 5; v++) begin
      drv_mode = tbl[v].mode;
      drv_bright = tbl[v].bright;
      for (int ch = 0; ch < 3; ch++) begin cl[ch] = 0; cb[ch] = 0; end
      for (int k = 0; k < tbl[v].cycles; k++) begin
        drv_act = (tbl[v].act_hold || k == 0) ? tbl[v].act : 3'b000;
        step();
        for (int ch = 0; ch < 3; ch++) begin
          cl[ch] += int'(obs_led[ch]);
          cb[ch] += int'(obs_busy[ch]);
        end
      end
      for (int ch = 0; ch < 3; ch++) begin
        check($sformatf("vec%0d_led_cnt_ch%0d", v, ch), 32'(cl[ch]), 32'(tbl[v].exp_led[ch]));
        check($sformatf("vec%0d_busy_cnt_ch%0d", v, ch), 32'(cb[ch]), 32'(tbl[v].exp_busy[ch]));
      end
    end

    // Retrigger: strobes at step 0 and 5 keep busy up through step 14.
    drv_mode = 6'b000011; drv_bright = 12'h00F;
    for (int k = 0; k < 20; k++) begin
      drv_act = (k == 0 || k == 5) ? 3'b001 : 3'b000;
      step();
      check($sformatf("retrig_busy%0d", k), 32'(obs_busy[0]), (k <= 14) ? 32'd1 : 32'd0);
    end

    // Reset mid-run with every channel lit and active.
    drv_mode = 6'b010101; drv_bright = 12'hFFF; drv_act = 3'b111;
    repeat (5) step();
    drv_reset = 1'b1;
    step();
    check("midreset_led", 32'(obs_led), 32'd0);
    check("midreset_busy", 32'(obs_busy), 32'd0);
    step();
    step();
    check("cnt_after_reset", 32'(dut.cnt_r), 32'd0);
    drv_reset = 1'b0; drv_act = 3'b000;

    // Breathe over a full period plus the wrap.
    drv_mode = 6'b000010; drv_bright = 12'h00F;
    for (int w = 0; w < 256; w++) duty[w] = 0;
    for (int k = 0; k < 4096 + 32; k++) begin
      step();
      if (k < 4096) duty[last_cnt[11:4]] += int'(obs_led[0]);
    end
`ifdef LED_ACTIVITY_GAMMA_EN
    check("duty_w64", 32'(duty[64]), 32'd2);
    check("duty_w192", 32'(duty[192]), 32'd3);
    check("duty_w248", 32'(duty[248]), 32'd13);
`else
    check("duty_w0", 32'(duty[0]), 32'd14);
    check("duty_w64", 32'(duty[64]), 32'd6);
    check("duty_w192", 32'(duty[192]), 32'd7);
    check("duty_w248", 32'(duty[248]), 32'd14);
`endif
    check("duty_w120", 32'(duty[120]), 32'd0);
    check("duty_w128", 32'(duty[128]), 32'd0);

    // OFF keeps the LED dark while busy tracks; switching to ACT mid-hold blinks next cycle.
    drv_mode = 6'd0; drv_bright = 12'hFFF; drv_act = 3'b000;
    guard = 0;
    cu2 = use_cnt();
    while (cu2[6:0] != 7'd62 && guard < 200) begin
      step();
      guard++;
      cu2 = use_cnt();
    end
    check("align_timeout", 32'(guard < 200), 32'd1);
    drv_act = 3'b001;
    step();
    drv_act = 3'b000;
    step();
    check("off_led", 32'(obs_led[0]), 32'd0);
    check("off_busy", 32'(obs_busy[0]), 32'd1);
    drv_mode = 6'b000011;
    step();
    check("switch_act_led", 32'(obs_led[0]), 32'd1);
    check("switch_act_busy", 32'(obs_busy[0]), 32'd1);
    repeat (16) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
